// File: rtl/axi_demux_pkg.sv
// AXI request/response bundles plus the demux state encodings and address decode helper
// shared by the axi_demux slice.
package axi_demux_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [LEN_W-1:0]  awlen;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [LEN_W-1:0]  arlen;
        logic              arvalid;
        logic              rready;
    } axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } axi_miso_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } demux_wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } demux_rstate_e;

    // Slices the port index out of the address; indices past the last port fold onto it.
    function automatic int unsigned addr_to_port(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned       sel_lsb,
                                                 input int unsigned       sel_w,
                                                 input int unsigned       num_ports);
        int unsigned idx;
        idx = (addr >> sel_lsb) & ((32'd1 << sel_w) - 32'd1);
        return (idx >= num_ports) ? num_ports - 1 : idx;
    endfunction

endpackage

// File: rtl/axi_demux_ch.sv
// One VALID/READY pair steered between a single upstream side and N downstream ports.
// up_i fans out to dn_o[sel_i]; dn_i[sel_i] returns on up_o; everything is 0 when en_i is low.
module axi_demux_ch #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic             up_o,
    output logic [N-1:0]     dn_o,
    input  logic [N-1:0]     dn_i
);

    always_comb begin
        up_o = 1'b0;
        dn_o = '0;
        for (int i = 0; i < N; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                dn_o[i] = up_i;
                up_o    = dn_i[i];
            end
        end
    end

endmodule

// File: rtl/axi_demux.sv
// 1-to-N AXI router: one burst in flight per direction, responses return from the addressed port.
// A transfer happens on the rising edge where VALID and READY are both high; VALID never waits on READY.
module axi_demux
    import axi_demux_pkg::*;
#(
    parameter int OUTPUT_NUM   = 4,
    parameter int ADDR_SEL_LSB = 12
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  axi_mosi_t                  s_axi_i,
    output axi_miso_t                  s_axi_o,
    output axi_mosi_t [OUTPUT_NUM-1:0] m_axi_o,
    input  axi_miso_t [OUTPUT_NUM-1:0] m_axi_i,
    output demux_wstate_e              dbg_wstate_o,
    output demux_rstate_e              dbg_rstate_o
);

    localparam int SEL_W = $clog2(OUTPUT_NUM);

    demux_wstate_e    wstate_q, wstate_d;
    demux_rstate_e    rstate_q, rstate_d;
    logic [SEL_W-1:0] wsel_q, wsel_d;
    logic [SEL_W-1:0] rsel_q, rsel_d;

    logic [SEL_W-1:0] aw_dec, ar_dec;
    logic aw_en, w_en, b_en, ar_en, r_en;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

    logic [OUTPUT_NUM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [OUTPUT_NUM-1:0] m_arvalid, m_arready, m_rvalid, m_rready;

    logic [ID_W-1:0]   sel_bid, sel_rid;
    logic [1:0]        sel_bresp, sel_rresp;
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_rlast;

    assign aw_dec = SEL_W'(addr_to_port(s_axi_i.awaddr, ADDR_SEL_LSB, SEL_W, OUTPUT_NUM));
    assign ar_dec = SEL_W'(addr_to_port(s_axi_i.araddr, ADDR_SEL_LSB, SEL_W, OUTPUT_NUM));

    always_comb begin
        sel_bid   = '0;
        sel_bresp = '0;
        sel_rid   = '0;
        sel_rresp = '0;
        sel_rdata = '0;
        sel_rlast = 1'b0;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            m_awready[i] = m_axi_i[i].awready;
            m_wready[i]  = m_axi_i[i].wready;
            m_bvalid[i]  = m_axi_i[i].bvalid;
            m_arready[i] = m_axi_i[i].arready;
            m_rvalid[i]  = m_axi_i[i].rvalid;
            if (wsel_q == SEL_W'(i)) begin
                sel_bid   = m_axi_i[i].bid;
                sel_bresp = m_axi_i[i].bresp;
            end
            if (rsel_q == SEL_W'(i)) begin
                sel_rid   = m_axi_i[i].rid;
                sel_rresp = m_axi_i[i].rresp;
                sel_rdata = m_axi_i[i].rdata;
                sel_rlast = m_axi_i[i].rlast;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wsel_q   <= '0;
            rsel_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
        end
    end

    assign aw_hs     = s_axi_i.awvalid & aw_ready;
    assign w_last_hs = s_axi_i.wvalid & w_ready & s_axi_i.wlast;
    assign b_hs      = b_valid & s_axi_i.bready;
    assign ar_hs     = s_axi_i.arvalid & ar_ready;
    assign r_last_hs = r_valid & s_axi_i.rready & sel_rlast;

    always_comb begin
        wstate_d = wstate_q;
        wsel_d   = wsel_q;
        unique case (wstate_q)
            W_IDLE: if (aw_hs) begin
                wstate_d = W_DATA;
                wsel_d   = aw_dec;
            end
            W_DATA:  if (w_last_hs) wstate_d = W_RESP;
            W_RESP:  if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase

        rstate_d = rstate_q;
        rsel_d   = rsel_q;
        if (rstate_q == R_IDLE) begin
            if (ar_hs) begin
                rstate_d = R_DATA;
                rsel_d   = ar_dec;
            end
        end else if (r_last_hs) begin
            rstate_d = R_IDLE;
        end
    end

    // Every steer is gated by reset so nothing handshakes while ARESETn is low.
    always_comb begin
        aw_en = ARESETn && (wstate_q == W_IDLE);
        w_en  = ARESETn && (wstate_q == W_DATA);
        b_en  = ARESETn && (wstate_q == W_RESP);
        ar_en = ARESETn && (rstate_q == R_IDLE);
        r_en  = ARESETn && (rstate_q == R_DATA);
    end

    axi_demux_ch #(.N(OUTPUT_NUM), .SEL_W(SEL_W)) u_aw (
        .sel_i(aw_dec), .en_i(aw_en), .up_i(s_axi_i.awvalid), .up_o(aw_ready),
        .dn_o(m_awvalid), .dn_i(m_awready));
    axi_demux_ch #(.N(OUTPUT_NUM), .SEL_W(SEL_W)) u_w (
        .sel_i(wsel_q), .en_i(w_en), .up_i(s_axi_i.wvalid), .up_o(w_ready),
        .dn_o(m_wvalid), .dn_i(m_wready));
    axi_demux_ch #(.N(OUTPUT_NUM), .SEL_W(SEL_W)) u_b (
        .sel_i(wsel_q), .en_i(b_en), .up_i(s_axi_i.bready), .up_o(b_valid),
        .dn_o(m_bready), .dn_i(m_bvalid));
    axi_demux_ch #(.N(OUTPUT_NUM), .SEL_W(SEL_W)) u_ar (
        .sel_i(ar_dec), .en_i(ar_en), .up_i(s_axi_i.arvalid), .up_o(ar_ready),
        .dn_o(m_arvalid), .dn_i(m_arready));
    axi_demux_ch #(.N(OUTPUT_NUM), .SEL_W(SEL_W)) u_r (
        .sel_i(rsel_q), .en_i(r_en), .up_i(s_axi_i.rready), .up_o(r_valid),
        .dn_o(m_rready), .dn_i(m_rvalid));

    // Payload is broadcast; only the handshake bits differ per port.
    always_comb begin
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            m_axi_o[i]         = s_axi_i;
            m_axi_o[i].awvalid = m_awvalid[i];
            m_axi_o[i].wvalid  = m_wvalid[i];
            m_axi_o[i].bready  = m_bready[i];
            m_axi_o[i].arvalid = m_arvalid[i];
            m_axi_o[i].rready  = m_rready[i];
        end
        s_axi_o         = '0;
        s_axi_o.awready = aw_ready;
        s_axi_o.wready  = w_ready;
        s_axi_o.bid     = sel_bid;
        s_axi_o.bresp   = sel_bresp;
        s_axi_o.bvalid  = b_valid;
        s_axi_o.arready = ar_ready;
        s_axi_o.rid     = sel_rid;
        s_axi_o.rresp   = sel_rresp;
        s_axi_o.rdata   = sel_rdata;
        s_axi_o.rlast   = sel_rlast;
        s_axi_o.rvalid  = r_valid;
    end

    assign dbg_wstate_o = wstate_q;
    assign dbg_rstate_o = rstate_q;

endmodule

// File: tb/tb_axi_demux.sv
// Bench for axi_demux: a 4-port instance and a 3-port instance, each port backed by a small RAM slave.
module tb_axi_demux;
  import axi_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mosi_t s_req [2];
  axi_miso_t s_rsp [2];
  axi_mosi_t [3:0] m4_req;
  axi_miso_t [3:0] m4_rsp;
  axi_mosi_t [2:0] m3_req;
  axi_miso_t [2:0] m3_rsp;
  demux_wstate_e wst4, wst3;
  demux_rstate_e rst4, rst3;

  int n_assert = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [int];
  int aw_cnt [7];
  int w_cnt [7];
  int ar_cnt [7];
  int steer_viol = 0;

  axi_demux #(.OUTPUT_NUM(4), .ADDR_SEL_LSB(12)) u_dut (
    .ACLK(clk), .ARESETn(rst_n), .s_axi_i(s_req[0]), .s_axi_o(s_rsp[0]),
    .m_axi_o(m4_req), .m_axi_i(m4_rsp), .dbg_wstate_o(wst4), .dbg_rstate_o(rst4));

  axi_demux #(.OUTPUT_NUM(3), .ADDR_SEL_LSB(12)) u_dut3 (
    .ACLK(clk), .ARESETn(rst_n), .s_axi_i(s_req[1]), .s_axi_o(s_rsp[1]),
    .m_axi_o(m3_req), .m_axi_i(m3_rsp), .dbg_wstate_o(wst3), .dbg_rstate_o(rst3));

  // RAM slaves: ports 0..3 serve u_dut, ports 4..6 serve u_dut3.
  for (genvar k = 0; k < 7; k++) begin : g_slv
    axi_mosi_t req;
    axi_miso_t rsp;
    logic wbusy, bpend, rbusy;
    logic [7:0] waddr, raddr, rcnt, rlen;
    logic [ID_W-1:0] bid_q, rid_q;
    logic [DATA_W-1:0] mem [256];
    int aw_n = 0;
    int w_n = 0;
    int ar_n = 0;

    if (k < 4) begin : g_a
      assign req = m4_req[k];
      assign m4_rsp[k] = rsp;
    end else begin : g_b
      assign req = m3_req[k-4];
      assign m3_rsp[k-4] = rsp;
    end
    assign aw_cnt[k] = aw_n;
    assign w_cnt[k] = w_n;
    assign ar_cnt[k] = ar_n;

    always_comb begin
      rsp = '0;
      rsp.awready = !wbusy && !bpend;
      rsp.wready = wbusy;
      rsp.bvalid = bpend;
      rsp.bid = bid_q;
      rsp.arready = !rbusy;
      rsp.rvalid = rbusy;
      rsp.rid = rid_q;
      rsp.rdata = mem[raddr];
      rsp.rlast = rbusy && (rcnt == rlen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wbusy <= 1'b0; bpend <= 1'b0; rbusy <= 1'b0;
        waddr <= '0; raddr <= '0; rcnt <= '0; rlen <= '0;
        bid_q <= '0; rid_q <= '0;
      end else begin
        if (req.awvalid && rsp.awready) begin
          wbusy <= 1'b1; waddr <= req.awaddr[9:2]; bid_q <= req.awid;
        end
        if (req.wvalid && rsp.wready) begin
          waddr <= waddr + 8'd1;
          if (req.wlast) begin wbusy <= 1'b0; bpend <= 1'b1; end
        end
        if (rsp.bvalid && req.bready) bpend <= 1'b0;
        if (req.arvalid && rsp.arready) begin
          rbusy <= 1'b1; raddr <= req.araddr[9:2]; rid_q <= req.arid;
          rlen <= req.arlen; rcnt <= '0;
        end
        if (rsp.rvalid && req.rready) begin
          if (rsp.rlast) rbusy <= 1'b0;
          else begin raddr <= raddr + 8'd1; rcnt <= rcnt + 8'd1; end
        end
      end
    end

    always @(posedge clk) begin
      if (req.awvalid && rsp.awready) aw_n <= aw_n + 1;
      if (req.wvalid && rsp.wready) begin
        w_n <= w_n + 1;
        mem[waddr] <= req.wdata;
      end
      if (req.arvalid && rsp.arready) ar_n <= ar_n + 1;
    end
  end

  // Routing monitor: at most one port may see any given VALID/READY at once.
  always @(negedge clk) begin
    logic [3:0] av, wv, arv, br, rr;
    logic [2:0] av3, wv3, arv3;
    for (int i = 0; i < 4; i++) begin
      av[i] = m4_req[i].awvalid; wv[i] = m4_req[i].wvalid; arv[i] = m4_req[i].arvalid;
      br[i] = m4_req[i].bready; rr[i] = m4_req[i].rready;
    end
    for (int i = 0; i < 3; i++) begin
      av3[i] = m3_req[i].awvalid; wv3[i] = m3_req[i].wvalid; arv3[i] = m3_req[i].arvalid;
    end
    if ($countones(av) > 1 || $countones(wv) > 1 || $countones(arv) > 1 ||
        $countones(br) > 1 || $countones(rr) > 1 || $countones(av3) > 1 ||
        $countones(wv3) > 1 || $countones(arv3) > 1)
      steer_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int d, input int which);
    case (which)
      0: return s_rsp[d].awready;
      1: return s_rsp[d].wready;
      2: return s_rsp[d].bvalid;
      3: return s_rsp[d].arready;
      default: return s_rsp[d].rvalid;
    endcase
  endfunction

  function automatic int key(input int d, input int addr);
    return d * 32'h0010_0000 + addr;
  endfunction

  task automatic wait_for(input int d, input int which, input string tag);
    int n = 0;
    @(negedge clk);
    while (!sig(d, which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sig(d, which)) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic aw_send(input int d, input int id, input int addr, input int len);
    s_req[d].awid = ID_W'(id);
    s_req[d].awaddr = ADDR_W'(addr);
    s_req[d].awlen = LEN_W'(len);
    s_req[d].awvalid = 1'b1;
    wait_for(d, 0, "aw");
    @(posedge clk); #1;
    s_req[d].awvalid = 1'b0;
  endtask

  task automatic w_send(input int d, input int addr, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_req[d].wdata = DATA_W'(base + i);
      s_req[d].wstrb = '1;
      s_req[d].wlast = (i == n - 1);
      s_req[d].wvalid = 1'b1;
      ref_mem[key(d, addr + 4 * i)] = DATA_W'(base + i);
      wait_for(d, 1, "w");
      @(posedge clk); #1;
    end
    s_req[d].wvalid = 1'b0;
    s_req[d].wlast = 1'b0;
  endtask

  task automatic b_recv(input int d, input int id);
    s_req[d].bready = 1'b1;
    wait_for(d, 2, "b");
    check("bid", 64'(s_rsp[d].bid), 64'(id));
    @(posedge clk); #1;
    s_req[d].bready = 1'b0;
  endtask

  task automatic write_burst(input int d, input int id, input int addr, input int len, input int base);
    aw_send(d, id, addr, len);
    w_send(d, addr, len + 1, base);
    b_recv(d, id);
  endtask

  task automatic read_burst(input int d, input int id, input int addr, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[key(d, addr + 4 * i)]);
    s_req[d].arid = ID_W'(id);
    s_req[d].araddr = ADDR_W'(addr);
    s_req[d].arlen = LEN_W'(len);
    s_req[d].arvalid = 1'b1;
    wait_for(d, 3, "ar");
    @(posedge clk); #1;
    s_req[d].arvalid = 1'b0;
    s_req[d].rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      logic [DATA_W-1:0] exp;
      wait_for(d, 4, "r");
      exp = exp_q.pop_front();
      check("rdata", 64'(s_rsp[d].rdata), 64'(exp));
      check("rlast", 64'(s_rsp[d].rlast), 64'(i == len));
      @(posedge clk); #1;
    end
    s_req[d].rready = 1'b0;
  endtask

  initial begin
    int aw0 [7];
    int w0 [7];
    int ar0 [7];
    time t0;
    logic [19:0] mv;

    s_req[0] = '0;
    s_req[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wstate", 64'(wst4), 64'(W_IDLE));
    check("rst_rstate", 64'(rst4), 64'(R_IDLE));
    check("rst_awready", 64'(s_rsp[0].awready), 64'd0);
    check("rst_arready", 64'(s_rsp[0].arready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: burst to 0x2010 lands only on port 2, BID echoes AWID
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    write_burst(0, 5, 32'h2010, 3, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_aw_route%0d", k), 64'(aw_cnt[k] - aw0[k]), (k == 2) ? 64'd1 : 64'd0);
      check($sformatf("t1_w_route%0d", k), 64'(w_cnt[k] - w0[k]), (k == 2) ? 64'd4 : 64'd0);
    end
    read_burst(0, 1, 32'h2010, 3);
    for (int k = 0; k < 4; k++)
      check($sformatf("t1_ar_route%0d", k), 64'(ar_cnt[k] - ar0[k]), (k == 2) ? 64'd1 : 64'd0);

    // 2: 3-port instance, index 3 folds onto port 2
    aw0 = aw_cnt; ar0 = ar_cnt;
    write_burst(1, 2, 32'h3000, 1, 32'h30);
    read_burst(1, 3, 32'h3000, 1);
    for (int k = 4; k < 7; k++) begin
      check($sformatf("t2_aw_route%0d", k - 4), 64'(aw_cnt[k] - aw0[k]), (k == 6) ? 64'd1 : 64'd0);
      check($sformatf("t2_ar_route%0d", k - 4), 64'(ar_cnt[k] - ar0[k]), (k == 6) ? 64'd1 : 64'd0);
    end

    // 3: concurrent write to port 0 and read from port 1
    write_burst(0, 4, 32'h1000, 3, 32'h10);
    t0 = $time;
    fork
      write_burst(0, 6, 32'h0000, 3, 32'h50);
      read_burst(0, 7, 32'h1000, 3);
    join
    check("t3_no_stall", 64'(($time - t0) / 10 <= 8), 64'd1);
    read_burst(0, 8, 32'h0000, 3);

    // 4: B backpressure holds the next AW off until the cycle after the B handshake
    aw_send(0, 8, 32'h0000, 0);
    w_send(0, 32'h0000, 1, 32'h70);
    s_req[0].awid = 4'h9;
    s_req[0].awaddr = 32'h1000;
    s_req[0].awlen = 8'd0;
    s_req[0].awvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_awready_hold", 64'(s_rsp[0].awready), 64'd0);
      check("t4_wstate_resp", 64'(wst4), 64'(W_RESP));
      check("t4_bvalid", 64'(s_rsp[0].bvalid), 64'd1);
      @(posedge clk); #1;
    end
    s_req[0].bready = 1'b1;
    @(negedge clk);
    check("t4_bid", 64'(s_rsp[0].bid), 64'h8);
    @(posedge clk); #1;
    s_req[0].bready = 1'b0;
    @(negedge clk);
    check("t4_awready_next", 64'(s_rsp[0].awready), 64'd1);
    check("t4_wstate_idle", 64'(wst4), 64'(W_IDLE));
    @(posedge clk); #1;
    s_req[0].awvalid = 1'b0;
    w_send(0, 32'h1000, 1, 32'h80);
    b_recv(0, 9);
    read_burst(0, 1, 32'h0000, 0);
    read_burst(0, 2, 32'h1000, 0);

    // 5: W presented before AW is held off
    s_req[0].wdata = 32'hC0;
    s_req[0].wstrb = '1;
    s_req[0].wlast = 1'b0;
    s_req[0].wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_wready_hold", 64'(s_rsp[0].wready), 64'd0);
      @(posedge clk); #1;
    end
    aw_send(0, 11, 32'h2100, 1);
    w_send(0, 32'h2100, 2, 32'hC0);
    b_recv(0, 11);
    read_burst(0, 3, 32'h2100, 1);

    // 6: reset during beat 2 of a 4-beat write
    aw_send(0, 12, 32'h0000, 3);
    for (int i = 0; i < 2; i++) begin
      s_req[0].wdata = 32'hE0 + i;
      s_req[0].wlast = 1'b0;
      s_req[0].wvalid = 1'b1;
      wait_for(0, 1, "t6_w");
      @(posedge clk); #1;
    end
    s_req[0].wdata = 32'hE2;
    s_req[0].awaddr = 32'h1000;
    s_req[0].awvalid = 1'b1;
    s_req[0].araddr = 32'h1000;
    s_req[0].arvalid = 1'b1;
    s_req[0].bready = 1'b1;
    s_req[0].rready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_s_vr", 64'({s_rsp[0].awready, s_rsp[0].wready, s_rsp[0].bvalid,
                          s_rsp[0].arready, s_rsp[0].rvalid}), 64'd0);
    for (int k = 0; k < 4; k++)
      mv[k*5 +: 5] = {m4_req[k].awvalid, m4_req[k].wvalid, m4_req[k].bready,
                      m4_req[k].arvalid, m4_req[k].rready};
    check("t6_m_vr", 64'(mv), 64'd0);
    check("t6_wstate", 64'(wst4), 64'(W_IDLE));
    @(posedge clk); #1;
    s_req[0] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    write_burst(0, 12, 32'h1000, 3, 32'hF0);
    read_burst(0, 2, 32'h1000, 3);

    check("steer_onehot", 64'(steer_viol), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
